psys_route_arbiter: RTL and testbench
=====================================

# psys_route_arbiter

Round-robin AXI-Stream arbiter that shares the 128-bit → 1536-bit packer among `NUM_SRC` independent 128-bit producers: weight, activation and bias readers. It sits directly upstream of the packer. It locks one source onto the packer input per grant and tags every forwarded beat with the source ID. It tracks the packer's 12-beat group boundary so that a grant never ends mid-group, except on `tlast`.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of requesting streams, 1..8.
- `DATA_W`, default 128: beat width in bits.
- `BEATS_PER_GROUP`, default 12: beats per packer output word (1536/128).
- `SRC_W`, default `$clog2(NUM_SRC)` (minimum 1): width of the source ID.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `s_axis_tdata`, in, `NUM_SRC*DATA_W`: source data, concatenated; source i occupies `[i*DATA_W +: DATA_W]`.
- `s_axis_tvalid`, in, `NUM_SRC`: per-source valid.
- `s_axis_tready`, out, `NUM_SRC`: per-source ready.
- `s_axis_tlast`, in, `NUM_SRC`: per-source end of packet.
- `m_axis_tdata`, out, `DATA_W`: data to the packer.
- `m_axis_tvalid`, out, 1: valid to the packer.
- `m_axis_tready`, in, 1: ready from the packer.
- `m_axis_tlast`, out, 1: end of packet to the packer.
- `m_axis_tid`, out, `SRC_W`: ID of the granted source.
- `busy`, out, 1: high while the block is in state XFER.
- `beat_cnt`, out, 4: beats accepted in the current group, 0..`BEATS_PER_GROUP`-1.

## Operation
State machine with two states: IDLE and XFER.

IDLE:
- All `s_axis_tready` are 0. `m_axis_tvalid` is 0.
- If any `s_axis_tvalid` is high, the picker selects the first requester at or after `rr_ptr`, searching upward and wrapping modulo `NUM_SRC`.
- At the clock edge the selected index is registered into `grant`, `beat_cnt` is cleared, and the FSM moves to XFER.

XFER:
- The datapath is a combinational mux on registered `grant`:
  - `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` follow source `grant`.
  - `s_axis_tready[grant]` equals `m_axis_tready`.
  - All other `s_axis_tready` bits are 0.
- A beat is accepted when `m_axis_tvalid & m_axis_tready`.
- On an accepted beat, `beat_cnt` increments. It wraps to 0 after `BEATS_PER_GROUP`-1.
- On an accepted beat with `tlast`:
  - `beat_cnt` clears to 0.
  - `rr_ptr` becomes `grant`+1, modulo `NUM_SRC`.
  - The FSM moves to IDLE.

Boundary conditions:
- Source drops `tvalid` mid-packet: the grant is held and `m_axis_tvalid` is 0. No other source is served.
- `m_axis_tready` low: the grant and all counters hold.
- `tlast` on beat 12, where the group boundary and packet end coincide: the block goes to IDLE and `beat_cnt` becomes 0.
- `tvalid` or `tlast` on a non-granted source is ignored.
- `NUM_SRC`=1: the block degenerates to a pass-through with one idle bubble per packet.
- `rst_n` low mid-packet: the block returns to IDLE with `rr_ptr`=0. An in-flight packet is dropped, and upstream must also be reset.

## Timing
- Reset values:
  - `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
  - `m_axis_tid`=0, `busy`=0, `beat_cnt`=0.
  - Internal state: `grant`=0, `rr_ptr`=0, state IDLE.
- Arbitration latency: a request seen in IDLE at cycle N gives `m_axis_tvalid` at cycle N+1, provided the source holds `tvalid`.
- Packet turnaround: exactly one dead cycle (IDLE) after every accepted `tlast`.
- Throughput in XFER: one beat per cycle.
- Signals from registers: `m_axis_tid` and `busy` are registered, as is `grant`. The mux path from `grant` through the data ports is combinational, with no extra pipeline stage.

## Configuration
Macro `PSYS_ARB_GROUP_SWITCH_EN`:
- Defined: the grant may also be released at a group boundary. Release happens on an accepted beat where `beat_cnt`=`BEATS_PER_GROUP`-1 without `tlast`, and only if any other source has `tvalid` high in that cycle.
  - On release, the FSM goes to IDLE and `rr_ptr` becomes `grant`+1.
  - The interrupted source resumes its packet on a later grant.
  - The packer sees complete 12-beat groups, each carrying a single `m_axis_tid`.
- Not defined: the grant is held until `tlast`, so each packet is atomic.

## Structure
- Package `psys_route_pkg` holds:
  - `DATA_W`=128, `OUT_W`=1536, `BEATS_PER_GROUP`=`OUT_W`/`DATA_W`.
  - The `arb_state_t` enum {IDLE, XFER}.
- Sub-module `psys_rr_picker` is purely combinational:
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `found` and `index`.

## Test plan
- Single source, 3-beat packet (`tlast` on beat 3), `m_axis_tready` always high:
  - One bubble cycle, then 3 consecutive beats with `m_axis_tid`=0 and `m_axis_tlast` on beat 3.
  - `busy` falls one cycle later.
- Sources 0 and 2 both requesting with 2-beat packets each, `rr_ptr`=0:
  - Order on the master side is 0, 2, 0, 2, with one dead cycle between packets.
- Backpressure: `m_axis_tready` low for 4 cycles mid-packet:
  - `beat_cnt`, `m_axis_tdata` and `grant` are stable.
  - `s_axis_tready[grant]`=0 throughout.
- 24-beat packet on source 1 with source 3 requesting:
  - Macro off: all 24 beats are from ID 1, then source 3 is served.
  - Macro on: 12 beats from ID 1, then a packet from ID 3, then the remaining 12 beats from ID 1.
- `tlast` on beat 12: `beat_cnt` reads 0 afterwards, the FSM goes to IDLE, and the next grant starts at `beat_cnt`=0.
- `rst_n` low for 1 cycle during beat 5:
  - All outputs return to reset values on the next cycle.
  - The next arbitration starts from source 0.

Source files
------------

// File: rtl/psys_route_pkg.sv
// Shared types and constants for the packer-side route arbiter.
package psys_route_pkg;

  localparam int DATA_W          = 128;
  localparam int OUT_W           = 1536;
  localparam int BEATS_PER_GROUP = OUT_W / DATA_W;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/psys_route_arbiter_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module psys_rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic               found,
  output logic [SRC_W-1:0]   index
);

  int cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      if (!found && req[cand]) begin
        found = 1'b1;
        index = SRC_W'(cand);
      end
    end
  end

endmodule

// File: rtl/psys_route_arbiter.sv
// Round-robin AXI-Stream arbiter in front of the 128->1536 packer.
// PSYS_ARB_GROUP_SWITCH_EN: also release the grant at a 12-beat group boundary.
module psys_route_arbiter
  import psys_route_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int DATA_W          = psys_route_pkg::DATA_W,
  parameter int BEATS_PER_GROUP = psys_route_pkg::BEATS_PER_GROUP,
  parameter int SRC_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [SRC_W-1:0]          m_axis_tid,
  output logic                      busy,
  output logic [3:0]                beat_cnt
);

  // Handshake: a beat moves on either side only in a cycle where valid and
  // ready are both high; valid never depends on ready on the master side.

  arb_state_t         state;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   next_ptr;
  logic               pick_found;
  logic [SRC_W-1:0]   pick_idx;
  logic               accept;
  logic               group_end;
  logic               release_grant;
  logic [DATA_W-1:0]  src_data [NUM_SRC];

  psys_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_picker (
    .req    (s_axis_tvalid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
    end
  end

  // Datapath is a pure mux on the registered grant; zero outside XFER.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == XFER) begin
      m_axis_tdata         = src_data[grant];
      m_axis_tvalid        = s_axis_tvalid[grant];
      m_axis_tlast         = s_axis_tlast[grant];
      s_axis_tready[grant] = m_axis_tready;
    end
  end

  assign accept    = m_axis_tvalid & m_axis_tready;
  assign group_end = (beat_cnt == 4'(BEATS_PER_GROUP - 1));
  assign next_ptr  = (int'(grant) == NUM_SRC - 1) ? '0 : grant + 1'b1;

`ifdef PSYS_ARB_GROUP_SWITCH_EN
  logic [NUM_SRC-1:0] grant_mask;
  logic               others_req;

  assign grant_mask    = NUM_SRC'(1) << grant;
  assign others_req    = |(s_axis_tvalid & ~grant_mask);
  assign release_grant = group_end & others_req;
`else
  assign release_grant = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      m_axis_tid <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant      <= pick_idx;
            m_axis_tid <= pick_idx;
            beat_cnt   <= '0;
            busy       <= 1'b1;
            state      <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            if (m_axis_tlast || release_grant) begin
              beat_cnt <= '0;
              rr_ptr   <= next_ptr;
              busy     <= 1'b0;
              state    <= IDLE;
            end else if (group_end) begin
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psys_route_arbiter.sv
// Directed bench for psys_route_arbiter: scoreboarded master stream plus cycle checks.
module tb_psys_route_arbiter;

  localparam int NS = 4;
  localparam int DW = 128;
  localparam int IW = 2;
  localparam int W  = 1 + IW + DW;

  logic             clk;
  logic             rst_n;
  logic [NS*DW-1:0] s_axis_tdata;
  logic [NS-1:0]    s_axis_tvalid;
  logic [NS-1:0]    s_axis_tready;
  logic [NS-1:0]    s_axis_tlast;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [IW-1:0]    m_axis_tid;
  logic             busy;
  logic [3:0]       beat_cnt;

  psys_route_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .busy          (busy),
    .beat_cnt      (beat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  int         src_len  [NS];
  int         src_beat [NS];
  int         src_pkt  [NS];
  int         src_left [NS];
  logic [NS-1:0] vmask;
  logic [NS-1:0] fire_prev;
  logic          rdy;

  function automatic logic [DW-1:0] mk(input int s, input int p, input int b);
    return {4{8'(s), 8'(p), 16'(b)}};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic start_src(input int s, input int len, input int n);
    src_len[s]  = len;
    src_left[s] = n;
    src_beat[s] = 0;
  endtask

  task automatic push_beats(input int s, input int p, input int first, input int count, input int len);
    for (int b = first; b < first + count; b++) begin
      exp_q.push_back({1'(b == len - 1), 2'(s), mk(s, p, b)});
    end
  endtask

  function automatic bit pending();
    bit r = 0;
    for (int i = 0; i < NS; i++) if (src_left[i] > 0) r = 1;
    return r;
  endfunction

  // One cycle: advance sources by last edge's handshakes, drive, then score the master beat.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      if (fire_prev[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0;
          src_pkt[i]++;
          src_left[i]--;
        end else begin
          src_beat[i]++;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      s_axis_tvalid[i]          = (src_left[i] > 0) && vmask[i];
      s_axis_tlast[i]           = (src_left[i] > 0) && (src_beat[i] == src_len[i] - 1);
      s_axis_tdata[i*DW +: DW]  = mk(i, src_pkt[i], src_beat[i]);
    end
    m_axis_tready = rdy;
    #1;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL extra_beat obs=%0h exp=none", {m_axis_tlast, m_axis_tid, m_axis_tdata});
      end else begin
        chk("beat", {m_axis_tlast, m_axis_tid, m_axis_tdata}, exp_q.pop_front());
      end
    end
    fire_prev = s_axis_tready & s_axis_tvalid;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || pending()) && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, W'(n < budget), W'(1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_tready"}, W'(s_axis_tready), W'(0));
    chk({tag, "_m_tvalid"}, W'(m_axis_tvalid), W'(0));
    chk({tag, "_m_tlast"},  W'(m_axis_tlast),  W'(0));
    chk({tag, "_m_tdata"},  W'(m_axis_tdata),  W'(0));
    chk({tag, "_m_tid"},    W'(m_axis_tid),    W'(0));
    chk({tag, "_busy"},     W'(busy),          W'(0));
    chk({tag, "_beat_cnt"}, W'(beat_cnt),      W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, p1, p2, p3;
    rst_n         = 1'b0;
    rdy           = 1'b1;
    vmask         = '1;
    fire_prev     = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      src_len[i] = 1; src_beat[i] = 0; src_pkt[i] = 0; src_left[i] = 0;
    end

    // reset state
    repeat (3) cycle();
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // sources 0 and 2, two 2-beat packets each: order 0,2,0,2 with a dead cycle between
    start_src(0, 2, 2);
    start_src(2, 2, 2);
    push_beats(0, 0, 0, 2, 2);
    push_beats(2, 0, 0, 2, 2);
    push_beats(0, 1, 0, 2, 2);
    push_beats(2, 1, 0, 2, 2);
    for (int k = 1; k <= 13; k++) begin
      cycle();
      chk("rr_valid", W'(m_axis_tvalid), W'((k % 3) != 1));
    end
    chk("rr_drained", W'(exp_q.size()), W'(0));

    // single source, 3-beat packet
    p0 = src_pkt[0];
    start_src(0, 3, 1);
    push_beats(0, p0, 0, 3, 3);
    cycle();
    chk("p3_bubble", W'(m_axis_tvalid), W'(0));
    cycle();
    chk("p3_busy", W'(busy), W'(1));
    chk("p3_tid", W'(m_axis_tid), W'(0));
    chk("p3_cnt0", W'(beat_cnt), W'(0));
    chk("p3_sready", W'(s_axis_tready), W'(4'b0001));
    cycle();
    chk("p3_cnt1", W'(beat_cnt), W'(1));
    cycle();
    chk("p3_last", W'(m_axis_tlast), W'(1));
    chk("p3_cnt2", W'(beat_cnt), W'(2));
    cycle();
    chk("p3_busy_fall", W'(busy), W'(0));
    chk("p3_idle_valid", W'(m_axis_tvalid), W'(0));
    chk("p3_cnt_clr", W'(beat_cnt), W'(0));

    // backpressure then tvalid drop on source 1, source 2 waiting
    p1 = src_pkt[1];
    p2 = src_pkt[2];
    start_src(1, 6, 1);
    start_src(2, 1, 1);
    push_beats(1, p1, 0, 6, 6);
    push_beats(2, p2, 0, 1, 1);
    cycle();
    cycle();
    chk("bp_tid", W'(m_axis_tid), W'(1));
    cycle();
    chk("bp_cnt1", W'(beat_cnt), W'(1));
    rdy = 1'b0;
    repeat (4) begin
      cycle();
      chk("bp_cnt_hold", W'(beat_cnt), W'(2));
      chk("bp_data_hold", W'(m_axis_tdata), W'(mk(1, p1, 2)));
      chk("bp_tid_hold", W'(m_axis_tid), W'(1));
      chk("bp_sready", W'(s_axis_tready), W'(0));
    end
    rdy = 1'b1;
    vmask[1] = 1'b0;
    repeat (2) begin
      cycle();
      chk("drop_valid", W'(m_axis_tvalid), W'(0));
      chk("drop_tid", W'(m_axis_tid), W'(1));
      chk("drop_sready", W'(s_axis_tready), W'(4'b0010));
      chk("drop_cnt", W'(beat_cnt), W'(2));
    end
    vmask[1] = 1'b1;
    run_until_idle("bp_drain", 40);

    // tlast on beat 12, then next packet starts from beat_cnt 0
    p2 = src_pkt[2];
    start_src(2, 12, 2);
    push_beats(2, p2, 0, 12, 12);
    push_beats(2, p2 + 1, 0, 12, 12);
    cycle();
    for (int b = 0; b < 12; b++) begin
      cycle();
      chk("g12_cnt", W'(beat_cnt), W'(b));
    end
    chk("g12_last", W'(m_axis_tlast), W'(1));
    cycle();
    chk("g12_idle", W'(busy), W'(0));
    chk("g12_cnt_clr", W'(beat_cnt), W'(0));
    cycle();
    chk("g12_regrant", W'(busy), W'(1));
    chk("g12_regrant_cnt", W'(beat_cnt), W'(0));
    run_until_idle("g12_drain", 40);

    // 24-beat packet on source 1 with source 3 requesting
    p1 = src_pkt[1];
    start_src(1, 24, 1);
    cycle();
    p3 = src_pkt[3];
    start_src(3, 2, 1);
`ifdef PSYS_ARB_GROUP_SWITCH_EN
    push_beats(1, p1, 0, 12, 24);
    push_beats(3, p3, 0, 2, 2);
    push_beats(1, p1, 12, 12, 24);
`else
    push_beats(1, p1, 0, 24, 24);
    push_beats(3, p3, 0, 2, 2);
`endif
    run_until_idle("g24_drain", 80);

    // reset during beat 5 of a source-3 packet, with rr_ptr left at 2
    p1 = src_pkt[1];
    start_src(1, 1, 1);
    push_beats(1, p1, 0, 1, 1);
    run_until_idle("pre_rst_drain", 20);
    p3 = src_pkt[3];
    start_src(3, 8, 1);
    push_beats(3, p3, 0, 5, 8);
    repeat (6) cycle();
    chk("mid_rst_cnt", W'(beat_cnt), W'(4));
    rst_n = 1'b0;
    src_left[3] = 0;
    src_beat[3] = 0;
    src_pkt[3]++;
    fire_prev = '0;
    cycle();
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    p0 = src_pkt[0];
    p3 = src_pkt[3];
    start_src(0, 1, 1);
    start_src(3, 1, 1);
    push_beats(0, p0, 0, 1, 1);
    push_beats(3, p3, 0, 1, 1);
    cycle();
    chk("post_rst_idle", W'(busy), W'(0));
    cycle();
    chk("post_rst_tid", W'(m_axis_tid), W'(0));
    run_until_idle("post_rst_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
